// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and the
// helpers that map shift levels onto pipeline stages.
package shift_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   // Each stage gets floor(shw/pipe) levels; the first (shw mod pipe) stages get one more.
   function automatic int stage_levels(input int shw, input int pipe, input int s);
      return shw / pipe + ((s < shw % pipe) ? 1 : 0);
   endfunction

   function automatic int stage_first(input int shw, input int pipe, input int s);
      return s * (shw / pipe) + ((s < shw % pipe) ? s : shw % pipe);
   endfunction

   function automatic int level_stage(input int shw, input int pipe, input int k);
      int st;
      st = 0;
      for (int s = 0; s < pipe; s++) begin
         if (k >= stage_first(shw, pipe, s)) st = s;
      end
      return st;
   endfunction

endpackage

// File: rtl/shift_level.sv
// One barrel-shifter level: conditionally shifts/rotates right or left by a
// fixed power-of-two amount.
module shift_level
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AMT   = 1
) (
   input  logic [WIDTH-1:0] data_i,
   input  op_e              op_i,
   input  logic             sign_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = data_i;
      if (en_i) begin
         case (op_i)
            OP_SLL:  data_o = {data_i[WIDTH-AMT-1:0], {AMT{1'b0}}};
            OP_SRL:  data_o = {{AMT{1'b0}}, data_i[WIDTH-1:AMT]};
            OP_SRA:  data_o = {{AMT{sign_i}}, data_i[WIDTH-1:AMT]};
            default: data_o = {data_i[AMT-1:0], data_i[WIDTH-1:AMT]};
         endcase
      end
   end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake and a
// pass-through tag; the whole pipe advances in lockstep on adv.
module shift_pipe
   import shift_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int PIPE  = 2,
   parameter  int TAG_W = 4,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero
);

   logic [WIDTH-1:0] data_q  [PIPE];
   logic [WIDTH-1:0] data_d  [PIPE];
   op_e              op_q    [PIPE];
   op_e              op_d    [PIPE];
   logic             sign_q  [PIPE];
   logic             sign_d  [PIPE];
   logic [SHW-1:0]   shamt_q [PIPE];
   logic [SHW-1:0]   shamt_d [PIPE];
   logic [TAG_W-1:0] tag_q   [PIPE];
   logic [TAG_W-1:0] tag_d   [PIPE];
   logic             vld_q   [PIPE];
   logic             vld_d   [PIPE];

   // Stage inputs: stage 0 sees the request port, stage s sees register s-1.
   logic [WIDTH-1:0] st_data  [PIPE];
   logic [WIDTH-1:0] st_res   [PIPE];
   op_e              st_op    [PIPE];
   logic             st_sign  [PIPE];
   logic [SHW-1:0]   st_shamt [PIPE];
   logic [TAG_W-1:0] st_tag   [PIPE];
   logic             st_vld   [PIPE];

   logic [WIDTH-1:0] lvl_in  [SHW];
   logic [WIDTH-1:0] lvl_out [SHW];
   logic             adv;

   assign adv       = !vld_q[PIPE-1] | out_ready;
   assign in_ready  = adv & rst_n;
   assign out_valid = vld_q[PIPE-1];
   assign out_data  = data_q[PIPE-1];
   assign out_tag   = tag_q[PIPE-1];
   assign out_zero  = (out_data == '0);

   for (genvar s = 0; s < PIPE; s++) begin : g_stage
      localparam int LAST = stage_first(SHW, PIPE, s) + stage_levels(SHW, PIPE, s) - 1;
      if (s == 0) begin : g_head
         assign st_data[s]  = in_data;
         assign st_op[s]    = op_e'(in_op);
         assign st_sign[s]  = in_data[WIDTH-1];
         assign st_shamt[s] = in_shamt;
         assign st_tag[s]   = in_tag;
         assign st_vld[s]   = in_valid & in_ready;
      end else begin : g_body
         assign st_data[s]  = data_q[s-1];
         assign st_op[s]    = op_q[s-1];
         assign st_sign[s]  = sign_q[s-1];
         assign st_shamt[s] = shamt_q[s-1];
         assign st_tag[s]   = tag_q[s-1];
         assign st_vld[s]   = vld_q[s-1];
      end
      assign st_res[s] = lvl_out[LAST];
   end

   // Levels run LSB-first; the first level of each stage starts from that stage's input.
   for (genvar k = 0; k < SHW; k++) begin : g_level
      localparam int S = level_stage(SHW, PIPE, k);
      localparam int F = stage_first(SHW, PIPE, S);
      if (k == F) begin : g_first
         assign lvl_in[k] = st_data[S];
      end else begin : g_chain
         assign lvl_in[k] = lvl_out[k-1];
      end
      shift_level #(
         .WIDTH (WIDTH),
         .AMT   (1 << k)
      ) u_level (
         .data_i (lvl_in[k]),
         .op_i   (st_op[S]),
         .sign_i (st_sign[S]),
         .en_i   (st_shamt[S][k]),
         .data_o (lvl_out[k])
      );
   end

   always_comb begin
      for (int s = 0; s < PIPE; s++) begin
         data_d[s]  = st_res[s];
         op_d[s]    = st_op[s];
         sign_d[s]  = st_sign[s];
         shamt_d[s] = st_shamt[s];
         tag_d[s]   = st_tag[s];
         vld_d[s]   = st_vld[s];
      end
   end

   // Stage register boundary: everything freezes together while adv is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < PIPE; s++) begin
            data_q[s]  <= '0;
            op_q[s]    <= OP_SLL;
            sign_q[s]  <= 1'b0;
            shamt_q[s] <= '0;
            tag_q[s]   <= '0;
            vld_q[s]   <= 1'b0;
         end
      end else if (adv) begin
         for (int s = 0; s < PIPE; s++) begin
            data_q[s]  <= data_d[s];
            op_q[s]    <= op_d[s];
            sign_q[s]  <= sign_d[s];
            shamt_q[s] <= shamt_d[s];
            tag_q[s]   <= tag_d[s];
            vld_q[s]   <= vld_d[s];
         end
      end
   end

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: directed cases, backpressure, mid-flight
// reset and randomized traffic against a plain-arithmetic shift model.
module tb_shift_pipe;

   localparam int WIDTH = 32;
   localparam int PIPE  = 2;
   localparam int TAG_W = 4;
   localparam int SHW   = $clog2(WIDTH);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_zero;

   shift_pipe #(.WIDTH(WIDTH), .PIPE(PIPE), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_out = 0;
   bit   rnd_done = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                              input int sh);
      logic [WIDTH-1:0] r;
      case (op)
         2'd0:    r = d << sh;
         2'd1:    r = d >> sh;
         2'd2:    r = $signed(d) >>> sh;
         default: r = (d >> sh) | (d << (WIDTH - sh));
      endcase
      return r;
   endfunction

   // Monitor: every handshake on the output side is checked against the queue head.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got tag %0d data 0x%0h, required no result",
                     out_tag, out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", out_tag, e.tag);
            check("out_zero", out_zero, e.data == '0);
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] d, input int sh,
                       input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] exp);
      bit acc;
      acc      = 0;
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      in_shamt = SHW'(sh);
      in_tag   = tag;
      for (int i = 0; i < 1000 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 within 1000 cycles");
      end else begin
         exp_q.push_back('{exp, tag});
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      #800_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      int base;
      int lat;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'd0;
      in_data   = '0;
      in_shamt  = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_out_zero", out_zero, 1);
      check("rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Directed values and latency
      send(2'd1, 32'h8000_0000, 31, 4'd1, 32'h0000_0001);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat + 1, PIPE);
      send(2'd0, 32'h0000_0001, 31, 4'd2, 32'h8000_0000);
      send(2'd2, 32'h8000_0000, 4, 4'd3, 32'hF800_0000);
      send(2'd2, 32'h7FFF_FFF0, 4, 4'd4, 32'h07FF_FFFF);
      send(2'd3, 32'h0000_0001, 1, 4'd5, 32'h8000_0000);
      for (int op = 0; op < 4; op++) send(op[1:0], 32'hA5A5_A5A5, 0, 4'(6 + op), 32'hA5A5_A5A5);
      send(2'd1, 32'h0000_0001, 1, 4'd10, 32'h0000_0000);
      drain("drain_directed");

      // Backpressure: stall three cycles as soon as tag 1 is presented
      base = n_out;
      fork
         begin
            send(2'd0, 32'h0000_0001, 4, 4'd1, 32'h0000_0010);
            send(2'd3, 32'h0000_000F, 4, 4'd2, 32'hF000_0000);
            send(2'd2, 32'h8000_0000, 31, 4'd3, 32'hFFFF_FFFF);
         end
         begin
            int w;
            w = 0;
            while (!out_valid && w < 50) begin
               @(posedge clk);
               #1;
               w++;
            end
            check("bp_first_valid", out_valid, 1);
            out_ready = 1'b0;
            check("bp_first_tag", out_tag, 1);
            repeat (3) begin
               @(posedge clk);
               #1;
               check("bp_in_ready", in_ready, 0);
               check("bp_hold_valid", out_valid, 1);
               check("bp_hold_data", out_data, 32'h0000_0010);
               check("bp_hold_tag", out_tag, 1);
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_bp");
      check("bp_count", n_out - base, 3);

      // Reset with ops in flight
      send(2'd0, 32'h0000_00FF, 8, 4'd11, 32'h0000_FF00);
      send(2'd1, 32'h0000_FF00, 8, 4'd12, 32'h0000_00FF);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_zero", out_zero, 1);
      check("mid_rst_in_ready", in_ready, 0);
      rst_n = 1'b1;
      base  = n_out;
      repeat (10) @(posedge clk);
      #1;
      check("no_ghost_after_reset", n_out - base, 0);

      // Random traffic with random backpressure
      base = n_out;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               logic [1:0]       op;
               logic [WIDTH-1:0] d;
               int               sh;
               op = 2'($urandom_range(0, 3));
               d  = WIDTH'({$urandom(), $urandom()});
               sh = $urandom_range(0, WIDTH - 1);
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               send(op, d, sh, TAG_W'($urandom()), model(op, d, sh));
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_random");
      check("random_count", n_out - base, 10000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_pipe.md
# shift_pipe

Pipelined, parametrised barrel shifter for the datapath's ALU shift path. It supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand with a variable shift amount. The pipeline depth is configurable, and a valid/ready handshake with a pass-through tag lets it sit between the operand-fetch stage and the writeback mux, including under backpressure.

## Interface
- WIDTH, 32, operand width; power of two, 8 to 64.
- PIPE, 2, number of register stages, 1 to log2(WIDTH); this is also the latency in cycles.
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- Derived localparam SHW = log2(WIDTH), the shift-amount width.

Ports, one clock; reset is synchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted on an edge where in_valid & in_ready.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0 to WIDTH-1.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result on an edge where out_valid & out_ready.
- out_data  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  high when out_data == 0.

## Operation
- Shifting uses SHW levels. Level k shifts by 2^k when shamt bit k is 1, otherwise it passes the value through.
- Levels are applied LSB-first.
- Op semantics per level:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with the sign bit of the original operand; the sign is carried down the pipe with op.
  - ROR wraps the low bits into the top.
- Levels are split across PIPE stages. Each stage takes floor(SHW/PIPE) levels; the first (SHW mod PIPE) stages take one extra. Example: WIDTH=32, PIPE=2 gives stage 0 levels 0-2 and stage 1 levels 3-4.
- Every stage registers data, op, residual shamt bits, tag and valid.
- The last stage register drives out_data, out_tag and out_valid. out_zero is computed combinationally from out_data.
- Global advance: adv = !out_valid | out_ready.
  - in_ready = adv & rst_n.
  - All stage registers load only when adv = 1.
  - Stage valid bits shift forward on adv; stage 0 valid loads in_valid & in_ready.
- Bubbles are not collapsed. A stall freezes the whole pipe, including empty stages.
- shamt 0 returns in_data unchanged for every op.
- Arithmetic is modulo WIDTH. No overflow or carry output exists.

## Timing
- Reset (rst_n low at an edge):
  - All valid bits become 0, so out_valid = 0.
  - out_data = 0, out_tag = 0, out_zero = 1.
  - All internal data registers become 0.
  - in_ready = 0 while rst_n = 0.
- Reset mid-operation discards every in-flight op. None emerge after reset is released.
- Latency: a request accepted at edge e has out_valid = 1 with its result after edge e+PIPE-1, provided adv stays 1. With PIPE=1, the result is visible in the cycle right after acceptance.
- Throughput is one op per cycle while out_ready = 1.
- While out_valid & !out_ready:
  - in_ready = 0.
  - out_data and out_tag hold stable.
  - No stage changes.
- Accept and emit on the same edge: legal, and results are not lost.
- Results leave in acceptance order.

## Structure
- The shared package shift_pkg holds:
  - op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROR.
  - a function computing the number of levels in stage s from SHW and PIPE.
- One sub-module, shift_level: combinational, parameters WIDTH and AMT, inputs data, op, sign and en, output data.
- shift_pipe instantiates SHW copies of shift_level in a generate loop and inserts the stage registers between them.

## Test plan
- SHIFT_PIPE with WIDTH=32, PIPE=2, out_ready=1.
  - Send SRL 0x80000000 shamt 31 -> out_data 0x00000001 two cycles after acceptance.
  - Then send SLL 0x00000001 shamt 31 -> 0x80000000.
- SRA 0x80000000 shamt 4 -> 0xF8000000; SRA 0x7FFFFFF0 shamt 4 -> 0x07FFFFFF; ROR 0x00000001 shamt 1 -> 0x80000000.
- Each op with shamt 0 on 0xA5A5A5A5 -> 0xA5A5A5A5, out_zero = 0. SRL 0x00000001 shamt 1 -> 0x00000000, out_zero = 1.
- Backpressure. Issue tags 1, 2, 3 back-to-back and drop out_ready for 3 cycles once tag 1 appears:
  - in_ready = 0 during the stall.
  - out_data and out_tag hold.
  - Tags then emerge 1, 2, 3 in order with none lost.
- Reset mid-flight. With two ops in the pipe, hold rst_n low for one edge:
  - out_valid = 0, out_data = 0, in_ready = 0 during reset.
  - Neither op appears afterwards.
- Builds with PIPE=1 and PIPE=5 (WIDTH=32), plus WIDTH=8 with PIPE=3:
  - latency equals PIPE.
  - 10000 random ops with random out_ready match a behavioural model exactly.
